// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding and default constants for the game controller
package game_pkg;

    typedef enum logic [1:0] {
        START   = 2'b00,
        PLAYING = 2'b01,
        OVER    = 2'b10
    } game_state_t;

    localparam int         SCORE_MAX_DEF = 99999;
    localparam logic [7:0] KEY_START_DEF = 8'h2C;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - two-flop synchroniser with registered rising-edge pulse
module sync_edge (
    input  logic Clk50,
    input  logic Reset,
    input  logic d,
    output logic rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic r_v1;
    logic r_v2;
    logic r_seen_low;
    logic r_rise;

    // r_v1/r_v2 track when r_s2 holds a real sample; a rise is only believed
    // after a genuine low has been seen, so a level held through reset is not an edge.
    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_seen_low <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_s1       <= d;
            r_s2       <= r_s1;
            r_s3       <= r_s2;
            r_v1       <= 1'b1;
            r_v2       <= r_v1;
            r_seen_low <= r_seen_low | (r_v2 & ~r_s2);
            r_rise     <= r_s2 & ~r_s3 & r_seen_low;
        end
    end

    assign rise = r_rise;

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - game state machine with frame-paced scoring and high-score tracking
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int         SCORE_DIV = 6,
    parameter int         OVER_LOCK = 30,
    parameter int         SCORE_MAX = SCORE_MAX_DEF,
    parameter logic [7:0] KEY_START = KEY_START_DEF
) (
    input  logic        Clk50,
    input  logic        Reset,
    input  logic        frame_Clk,
    input  logic [7:0]  keycode,
    input  logic        Dead,
    output logic [1:0]  Game_State,
    output logic [31:0] score,
    output logic [31:0] high_score,
    output logic        new_high,
    output logic        frame_tick
);

    localparam int                DIV_W     = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam int                LOCK_W    = $clog2(OVER_LOCK + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCORE_DIV - 1);
    localparam logic [LOCK_W-1:0] LOCK_END  = LOCK_W'(OVER_LOCK);
    localparam logic [31:0]       SCORE_TOP = 32'(SCORE_MAX);

    logic              w_frame_tick;
    logic              w_key_press;
    logic              r_key_d;
    logic              r_key_prev;
    logic              r_key_v;
    logic              r_key_ok;
    game_state_t       r_state;
    logic [31:0]       r_score;
    logic [31:0]       r_high;
    logic              r_new_high;
    logic [DIV_W-1:0]  r_div;
    logic [LOCK_W-1:0] r_lock;

    sync_edge u_frame_sync (
        .Clk50 (Clk50),
        .Reset (Reset),
        .d     (frame_Clk),
        .rise  (w_frame_tick)
    );

    // Same guard as the frame path: a key held across reset never counts as a press.
    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) begin
            r_key_d    <= 1'b0;
            r_key_prev <= 1'b0;
            r_key_v    <= 1'b0;
            r_key_ok   <= 1'b0;
        end else begin
            r_key_d    <= (keycode == KEY_START);
            r_key_prev <= r_key_d;
            r_key_v    <= 1'b1;
            r_key_ok   <= r_key_ok | (r_key_v & ~r_key_d);
        end
    end

    assign w_key_press = r_key_d & ~r_key_prev & r_key_ok;

    always_ff @(posedge Clk50 or posedge Reset) begin
        if (Reset) begin
            r_state    <= START;
            r_score    <= 32'd0;
            r_high     <= 32'd0;
            r_new_high <= 1'b0;
            r_div      <= '0;
            r_lock     <= '0;
        end else begin
            case (r_state)
                START: begin
                    if (w_key_press) begin
                        r_state    <= PLAYING;
                        r_score    <= 32'd0;
                        r_div      <= '0;
                        r_new_high <= 1'b0;
                    end
                end
                PLAYING: begin
                    // Dead wins over a coincident frame tick: the final frame scores nothing.
                    if (Dead) begin
                        r_state <= OVER;
                        r_lock  <= '0;
                        if (r_score > r_high) begin
                            r_high     <= r_score;
                            r_new_high <= 1'b1;
                        end else begin
                            r_new_high <= 1'b0;
                        end
                    end else if (w_frame_tick) begin
                        if (r_div == DIV_LAST) begin
                            r_div <= '0;
                            if (r_score < SCORE_TOP) begin
                                r_score <= r_score + 32'd1;
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                end
                OVER: begin
                    if (w_key_press && (r_lock == LOCK_END)) begin
                        r_state    <= PLAYING;
                        r_score    <= 32'd0;
                        r_div      <= '0;
                        r_new_high <= 1'b0;
                    end else if (w_frame_tick && (r_lock != LOCK_END)) begin
                        r_lock <= r_lock + 1'b1;
                    end
                end
                default: begin
                    r_state <= START;
                end
            endcase
        end
    end

    assign Game_State = r_state;
    assign score      = r_score;
    assign high_score = r_high;
    assign new_high   = r_new_high;
    assign frame_tick = w_frame_tick;

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb/tb_game_state_ctrl.sv - directed self-checking bench for game_state_ctrl
module tb_game_state_ctrl;

    logic        Clk50;
    logic        Reset;
    logic        frame_Clk;
    logic [7:0]  keycode;
    logic        Dead;
    logic [1:0]  Game_State;
    logic [31:0] score;
    logic [31:0] high_score;
    logic        new_high;
    logic        frame_tick;

    logic        sat_dead;
    logic [1:0]  sat_state;
    logic [31:0] sat_score;
    logic [31:0] sat_high;
    logic        sat_new_high;
    logic        sat_tick;

    int n_checks;
    int n_errors;
    int tick_cnt;
    int wide_cnt;
    int play_entries;
    int tick_mark;
    logic       prev_tick;
    logic [1:0] prev_state;

    game_state_ctrl dut (
        .Clk50      (Clk50),
        .Reset      (Reset),
        .frame_Clk  (frame_Clk),
        .keycode    (keycode),
        .Dead       (Dead),
        .Game_State (Game_State),
        .score      (score),
        .high_score (high_score),
        .new_high   (new_high),
        .frame_tick (frame_tick)
    );

    game_state_ctrl #(.SCORE_DIV(1), .SCORE_MAX(3)) dut_sat (
        .Clk50      (Clk50),
        .Reset      (Reset),
        .frame_Clk  (frame_Clk),
        .keycode    (keycode),
        .Dead       (sat_dead),
        .Game_State (sat_state),
        .score      (sat_score),
        .high_score (sat_high),
        .new_high   (sat_new_high),
        .frame_tick (sat_tick)
    );

    initial Clk50 = 1'b0;
    always #5 Clk50 = ~Clk50;

    always @(negedge Clk50) begin
        if (frame_tick) tick_cnt++;
        if (frame_tick && prev_tick) wide_cnt++;
        if (Game_State == 2'b01 && prev_state != 2'b01) play_entries++;
        prev_tick  = frame_tick;
        prev_state = Game_State;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk50) frame_Clk = 1'b1;
            repeat (4) @(negedge Clk50);
            frame_Clk = 1'b0;
            repeat (4) @(negedge Clk50);
        end
    endtask

    task automatic press();
        @(negedge Clk50) keycode = 8'h2C;
        repeat (4) @(negedge Clk50);
        keycode = 8'h00;
        repeat (2) @(negedge Clk50);
    endtask

    initial begin
        n_checks = 0; n_errors = 0; tick_cnt = 0; wide_cnt = 0; play_entries = 0;
        prev_tick = 1'b0; prev_state = 2'b00;
        Reset = 1'b1; frame_Clk = 1'b0; keycode = 8'h00; Dead = 1'b0; sat_dead = 1'b0;
        repeat (3) @(negedge Clk50);
        chk("rst_state", 32'(Game_State), 32'd0);
        chk("rst_score", score, 32'd0);
        chk("rst_tick", 32'(frame_tick), 32'd0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk50);

        press();
        chk("start_state", 32'(Game_State), 32'd1);
        chk("start_score", score, 32'd0);
        chk("start_once", 32'(play_entries), 32'd1);

        frame(3);
        chk("sat_reach", sat_score, 32'd3);
        frame(1);
        chk("sat_hold", sat_score, 32'd3);
        frame(56);
        chk("score_60", score, 32'd10);
        chk("ticks_60", 32'(tick_cnt), 32'd60);
        chk("tick_width", 32'(wide_cnt), 32'd0);
        chk("sat_hold_60", sat_score, 32'd3);

        frame(5);
        chk("pre_dead_score", score, 32'd10);
        // Dead lands exactly in the cycle frame_tick is high, with div_cnt at 5
        @(negedge Clk50) frame_Clk = 1'b1;
        repeat (3) @(negedge Clk50);
        chk("tick_at_dead", 32'(frame_tick), 32'd1);
        Dead = 1'b1;
        @(negedge Clk50);
        chk("dead_state", 32'(Game_State), 32'd2);
        chk("dead_score", score, 32'd10);
        chk("dead_high", high_score, 32'd10);
        chk("dead_new_high", 32'(new_high), 32'd1);
        frame_Clk = 1'b0;
        repeat (4) @(negedge Clk50);
        chk("over_ignores_dead", 32'(Game_State), 32'd2);
        Dead = 1'b0;

        frame(10);
        press();
        chk("lock_10", 32'(Game_State), 32'd2);
        frame(19);
        press();
        chk("lock_29", 32'(Game_State), 32'd2);
        chk("over_frozen", score, 32'd10);
        frame(1);
        press();
        chk("restart_state", 32'(Game_State), 32'd1);
        chk("restart_score", score, 32'd0);
        chk("restart_new_high", 32'(new_high), 32'd0);

        frame(12);
        chk("game2_score", score, 32'd2);
        @(negedge Clk50) Dead = 1'b1;
        repeat (2) @(negedge Clk50);
        Dead = 1'b0;
        chk("game2_state", 32'(Game_State), 32'd2);
        chk("game2_high", high_score, 32'd10);
        chk("game2_new_high", 32'(new_high), 32'd0);

        frame(30);
        press();
        chk("game3_state", 32'(Game_State), 32'd1);
        frame(7);
        chk("game3_score", score, 32'd1);

        @(negedge Clk50);
        #1 Reset = 1'b1;
        #1;
        chk("async_state", 32'(Game_State), 32'd0);
        chk("async_score", score, 32'd0);
        chk("async_high", high_score, 32'd0);
        chk("async_new_high", 32'(new_high), 32'd0);
        chk("async_tick", 32'(frame_tick), 32'd0);

        frame_Clk = 1'b1;
        keycode = 8'h2C;
        repeat (2) @(negedge Clk50);
        Reset = 1'b0;
        tick_mark = tick_cnt;
        repeat (10) @(negedge Clk50);
        chk("held_no_press", 32'(Game_State), 32'd0);
        chk("held_no_tick", 32'(tick_cnt), 32'(tick_mark));
        frame_Clk = 1'b0;
        keycode = 8'h00;
        repeat (4) @(negedge Clk50);
        press();
        chk("post_rst_start", 32'(Game_State), 32'd1);
        frame(1);
        chk("post_rst_tick", 32'(tick_cnt), 32'(tick_mark + 1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- SCORE_DIV, 6: frame ticks per score point.
- OVER_LOCK, 30: frame ticks after game over during which restart is ignored.
- SCORE_MAX, 99999: score saturation value (five displayed digits).
- KEY_START, 8'h2C: keycode that starts or restarts a game.

REQ-002 SHALL have these ports (name, direction, width, meaning):
- Clk50, in, 1: sole clock.
- Reset, in, 1: asynchronous, active-high reset.
- frame_Clk, in, 1: asynchronous frame strobe, sampled on Clk50.
- keycode, in, 8: current key code.
- Dead, in, 1: collision flag from game logic, level-sensitive.
- Game_State, out, 2: 00 START, 01 PLAYING, 10 OVER.
- score, out, 32 (int): current score, 0..SCORE_MAX.
- high_score, out, 32 (int): best score since reset.
- new_high, out, 1: last game set a new high score.
- frame_tick, out, 1: one-Clk50 pulse per frame_Clk rising edge.

Function
REQ-003 SHALL synchronise frame_Clk through two flops, then rising-edge detect it; frame_tick asserts exactly one Clk50 cycle, 3 cycles after a frame_Clk rise.

REQ-004 SHALL register keycode==KEY_START and form key_press as its 0->1 edge; a held key yields one key_press only.

REQ-005 SHALL implement FSM state transitions:
- START->PLAYING on key_press.
- PLAYING->OVER when Dead=1.
- OVER->PLAYING on key_press once lock_cnt==OVER_LOCK.
- No other transitions; state 11 SHALL never be reached.

REQ-006 SHALL, on any transition into PLAYING, clear score and div_cnt in the same edge.

REQ-007 SHALL, in PLAYING with frame_tick=1 and Dead=0, do one of:
- if div_cnt==SCORE_DIV-1: clear div_cnt and increment score;
- otherwise: increment div_cnt.

REQ-008 SHALL hold score at SCORE_MAX once it is reached; it never wraps.

REQ-009 SHALL give Dead priority: when Dead and frame_tick coincide in PLAYING, enter OVER with no increment.

REQ-010 SHALL ignore Dead in START and OVER.

REQ-011 SHALL, on the PLAYING->OVER edge, apply the high-score rule:
- if score>high_score: set high_score=score and new_high=1;
- otherwise: new_high=0.

REQ-012 SHALL clear new_high on the transition into PLAYING.

REQ-013 SHALL, on entry to OVER, clear lock_cnt; it then increments once per frame_tick and saturates at OVER_LOCK.

REQ-014 SHALL discard key_press in OVER while lock_cnt<OVER_LOCK; the key must be released and pressed again.

REQ-015 SHALL hold score frozen in START and OVER.

REQ-016 SHALL drive every output from a register, with no combinational path from input to output.

Reset
REQ-017 SHALL, on Reset=1, asynchronously force:
- Game_State=START;
- score=0, high_score=0, new_high=0, frame_tick=0;
- div_cnt=0, lock_cnt=0;
- synchroniser and key flops to 0.

REQ-018 SHALL, on Reset deassertion, produce no frame_tick or key_press until a genuine 0->1 input edge occurs.

REQ-019 SHALL treat Reset asserted mid-game like power-on reset; high_score is lost.

Structure
REQ-020 SHALL define these in shared package game_pkg:
- game_state_t enum {START=2'b00, PLAYING=2'b01, OVER=2'b10};
- SCORE_MAX and KEY_START defaults.

REQ-021 SHALL place synchroniser plus edge detector in sub-module sync_edge (ports Clk50, Reset, d, rise), instantiated for frame_Clk.

REQ-022 SHALL connect Game_State and score directly to the draw_over stage without extra logic.

Verification
REQ-023 SHALL cover these directed scenarios:
- Reset, pulse keycode=8'h2C for 4 cycles -> Game_State 00->01 exactly once, score=0.
- PLAYING, 60 frame_Clk rises, Dead=0 -> score=10; frame_tick count=60, each pulse 1 cycle wide.
- Force score near max (SCORE_DIV=1, preload 99998), 3 frame ticks -> score 99999, held.
- Dead asserted in the same cycle as frame_tick with div_cnt=5 -> OVER, score unchanged, high_score=score, new_high=1.
- In OVER, key_press after 10 ticks -> stays 10. Release, 20 more ticks, press -> 01, score=0, new_high=0.
- Second game dies at a lower score -> high_score unchanged, new_high=0. Reset mid-PLAYING -> all outputs 0 asynchronously.
